// File: rtl/log_expand_stream.sv
// Log-code to linear-count expander: code k becomes 2^min(k,20)-1, built one
// bit per cycle, presented with a wrapping bin index over a valid/ready stream.
module log_expand_stream #(
    parameter int NUM_BINS = 1024,
    parameter int IDX_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_code,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [19:0]      out_data,
    output logic             out_sat,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last
);

    // Handshake: a transfer happens on any rising edge where valid and ready
    // are both high; valid never depends on ready, and a presented output
    // holds all of its fields until it transfers.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);
    localparam logic [4:0]       MAX_CNT  = 5'd20;

    state_t           state, state_next;
    logic [4:0]       cnt, cnt_next;
    logic [19:0]      acc, acc_next;
    logic             sat, sat_next;
    logic [19:0]      data_q, data_next;
    logic             sat_q, sat_q_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [4:0]       code_cap;
    logic             code_sat;
    logic             accept;
    logic             transfer;

    assign code_sat = (in_code > 8'd20);
    assign code_cap = code_sat ? MAX_CNT : in_code[4:0];
    assign accept   = in_valid && (state == IDLE);
    assign transfer = out_ready && (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            sat    <= 1'b0;
            data_q <= '0;
            sat_q  <= 1'b0;
            idx    <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            acc    <= acc_next;
            sat    <= sat_next;
            data_q <= data_next;
            sat_q  <= sat_q_next;
            idx    <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        acc_next   = acc;
        sat_next   = sat;
        data_next  = data_q;
        sat_q_next = sat_q;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_next   = code_cap;
                    acc_next   = '0;
                    sat_next   = code_sat;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != 5'd0) begin
                    acc_next = {acc[18:0], 1'b1};
                    cnt_next = cnt - 5'd1;
                end else begin
                    // Output registers only change here, so they keep the
                    // previously transferred result while idle or shifting.
                    data_next  = acc;
                    sat_q_next = sat;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (transfer) begin
                    idx_next   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = data_q;
    assign out_sat   = sat_q;
    assign out_idx   = idx;
    assign out_last  = (idx == LAST_IDX);

endmodule

// File: tb/tb_log_expand_stream.sv
// Self-checking bench for log_expand_stream: directed scenarios plus random
// codes compared against an arithmetic model of the code-to-count mapping.
module tb_log_expand_stream;

    localparam int NB = 16;
    localparam int IW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [7:0]    in_code;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [19:0]   out_data;
    logic          out_sat;
    logic [IW-1:0] out_idx;
    logic          out_last;

    int checks = 0;
    int errors = 0;
    int exp_idx = 0;
    logic [19:0] exp_q[$];

    log_expand_stream #(.NUM_BINS(NB), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .out_idx(out_idx),
        .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count = 2^min(k,20)-1, latency = min(k,20)+1 cycles.
    function automatic int capped(input int k);
        return (k > 20) ? 20 : k;
    endfunction

    function automatic logic [19:0] ref_data(input int k);
        longint v;
        v = (longint'(1) << capped(k)) - 1;
        return v[19:0];
    endfunction

    // Called #1 after a rising edge with the DUT idle. hold = cycles of
    // backpressure after out_valid; noisy keeps in_valid high with changing
    // in_code while the code is in flight.
    task automatic do_code(input int k, input int hold, input bit noisy);
        int lat;
        logic [19:0] ed;
        logic es;
        ed = ref_data(k);
        es = (k > 20);
        exp_q.push_back(ed);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready code=%0d got %b want 1", k, in_ready);
        end
        in_valid  = 1'b1;
        in_code   = k[7:0];
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        if (noisy) in_code = 8'($urandom);
        else in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready code=%0d cyc=%0d got %b want 0", k, lat, in_ready);
            end
            @(posedge clk);
            #1;
            lat++;
            if (noisy) in_code = 8'($urandom);
        end
        in_valid = 1'b0;
        checks++;
        if (lat !== capped(k) + 1) begin
            errors++;
            $display("FAIL latency code=%0d got %0d want %0d", k, lat, capped(k) + 1);
        end
        if (!out_valid) begin
            out_ready = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        checks++;
        if (out_data !== ed || out_sat !== es) begin
            errors++;
            $display("FAIL data code=%0d got %h/%b want %h/%b", k, out_data, out_sat, ed, es);
        end
        checks++;
        if (out_idx !== IW'(exp_idx) || out_last !== (exp_idx == NB - 1)) begin
            errors++;
            $display("FAIL index code=%0d got %0d/%b want %0d/%b", k, out_idx, out_last,
                     exp_idx, (exp_idx == NB - 1));
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== ed || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold code=%0d cyc=%0d got v=%b d=%h r=%b want v=1 d=%h r=0",
                         k, i, out_valid, out_data, in_ready, ed);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_idx = (exp_idx + 1) % NB;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL after_xfer code=%0d got v=%b r=%b d=%h want v=0 r=1 d=%h",
                     k, out_valid, in_ready, out_data, ed);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_code = 8'd5; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 20'd0 ||
            out_sat !== 1'b0 || out_idx !== '0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset got r=%b v=%b d=%h s=%b i=%0d l=%b want 1 0 0 0 0 0",
                     in_ready, out_valid, out_data, out_sat, out_idx, out_last);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b1;
        exp_idx = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        for (int n = 0; n < NB + 2; n++) begin
            do_code($urandom_range(0, 6), 0, 1'b0);
            if (n >= NB) begin
                checks++;
                if (exp_idx !== n - NB + 1) begin
                    errors++;
                    $display("FAIL wrap n=%0d got %0d want %0d", n, exp_idx, n - NB + 1);
                end
            end
        end
    endtask

    task automatic test_directed();
        int codes[4] = '{0, 1, 8, 20};
        foreach (codes[i]) do_code(codes[i], 0, 1'b0);
    endtask

    task automatic test_saturate();
        do_code(21, 0, 1'b0);
        do_code(255, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_code(5, 10, 1'b0);
    endtask

    task automatic test_noisy_input();
        do_code(4, 0, 1'b1);
        do_code(11, 2, 1'b1);
    endtask

    task automatic test_reset_mid_shift();
        in_valid = 1'b1; in_code = 8'd15;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== '0) begin
            errors++;
            $display("FAIL reset_shift got r=%b v=%b i=%0d want 1 0 0", in_ready, out_valid, out_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_idx = 0;
        @(posedge clk);
        #1;
        do_code(3, 0, 1'b0);
        // Reset while a result is waiting must drop it silently.
        in_valid = 1'b1; in_code = 8'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 20'd3) begin
            errors++;
            $display("FAIL reset_done_pre got v=%b d=%h want 1 00003", out_valid, out_data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_idx !== '0 || out_data !== 20'd0) begin
            errors++;
            $display("FAIL reset_done got v=%b i=%0d d=%h want 0 0 0", out_valid, out_idx, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_idx = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int k;
        for (int n = 0; n < 40; n++) begin
            k = ($urandom_range(0, 9) == 0) ? $urandom_range(21, 255) : $urandom_range(0, 22);
            do_code(k, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_directed();
        test_saturate();
        test_backpressure();
        test_noisy_input();
        test_reset_mid_shift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
